seq_chunk_adder: RTL and testbench

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

---
 rtl/adder_pkg.sv | 23 ++
 rtl/chunk_adder.sv | 29 ++
 rtl/seq_chunk_adder.sv | 117 +++++++++++
 tb/tb_seq_chunk_adder.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM states and parameter
// legality helpers used at elaboration time.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  // Chunk index width; a single-chunk adder still keeps a 1-bit index.
  function automatic int idx_bits(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational W-bit ripple adder slice; also exposes the carry into its MSB
// so the caller can derive signed overflow on the final chunk.
module chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[W];
  assign cmsb = c[W-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: operands are captured once, then summed one
// CHUNK-bit slice per cycle, LSB slice first, through a single chunk_adder.
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           fsm_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = idx_bits(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [CHUNK-1:0] a_c, b_c, s_c;
  logic             co_c, cmsb_c;
  logic             accept;
  int               base;

  assign base = int'(idx_q) * CHUNK;
  assign a_c  = a_q[base +: CHUNK];
  assign b_c  = b_q[base +: CHUNK];

  chunk_adder #(.W(CHUNK)) u_chunk (
    .a    (a_c),
    .b    (b_c),
    .cin  (carry_q),
    .s    (s_c),
    .cout (co_c),
    .cmsb (cmsb_c)
  );

  // Handshakes: a transfer occurs on a rising clk edge where valid and ready
  // are both high; ready never depends on valid, and a held result stays
  // unchanged until the consumer takes it.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Subtraction is A + ~B + 1, so the caller's cin is not used.
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub | cin;
        idx_q   <= '0;
      end else if (state_q == CALC) begin
        sum_q[base +: CHUNK] <= s_c;
        carry_q              <= co_c;
        if (idx_q == LAST) begin
          idx_q  <= '0;
          cout_q <= co_c;
          ovf_q  <= cmsb_c ^ co_c;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: a 16/4 instance (index 0) and a 12/12 instance
// (index 1), checked every cycle against an arithmetic reference model.
module tb_seq_chunk_adder;
  import adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic        rst_n_s     [2];
  logic        in_valid_s  [2];
  logic        sub_s       [2];
  logic        cin_s       [2];
  logic        out_ready_s [2];
  logic [15:0] a_s         [2];
  logic [15:0] b_s         [2];
  int          rmode       [2];  // 0: ready=1, 1: random, 3: manual

  logic        in_ready0, out_valid0, cout0, ovf0;
  logic [15:0] sum0;
  state_t      st0;
  logic        in_ready1, out_valid1, cout1, ovf1;
  logic [11:0] sum1;
  state_t      st1;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_w16 (
    .clk(clk), .rst_n(rst_n_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready0),
    .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]), .sub(sub_s[0]),
    .out_valid(out_valid0), .out_ready(out_ready_s[0]),
    .sum(sum0), .cout(cout0), .ovf(ovf0), .fsm_state(st0)
  );

  seq_chunk_adder #(.WIDTH(12), .CHUNK(12)) u_w12 (
    .clk(clk), .rst_n(rst_n_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready1),
    .a(a_s[1][11:0]), .b(b_s[1][11:0]), .cin(cin_s[1]), .sub(sub_s[1]),
    .out_valid(out_valid1), .out_ready(out_ready_s[1]),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .fsm_state(st1)
  );

  function automatic int wid(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic int nch(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  typedef struct packed {
    logic        ov;
    logic        ir;
    logic [17:0] res;  // {ovf, cout, sum zero-extended to 16}
  } obs_t;

  function automatic obs_t obs(input int k);
    obs_t o;
    if (k == 0) begin
      o.ov = out_valid0; o.ir = in_ready0; o.res = {ovf0, cout0, sum0};
    end else begin
      o.ov = out_valid1; o.ir = in_ready1; o.res = {ovf1, cout1, 4'h0, sum1};
    end
    return o;
  endfunction

  // ---------------- reference model ----------------
  // Plain integer arithmetic: unsigned result for sum/cout, signed range test for ovf.
  function automatic logic [17:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                        input logic ci, input logic sb);
    longint m, ua, ub, sa, sbv, full, sres;
    logic   c, v;
    m   = longint'(1) << w;
    ua  = longint'(av) & (m - 1);
    ub  = longint'(bv) & (m - 1);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    if (sb) begin
      full = ua - ub;
      c    = (ua >= ub);
      sres = sa - sbv;
    end else begin
      full = ua + ub + longint'(ci);
      c    = (full >= m);
      sres = sa + sbv + longint'(ci);
    end
    v    = (sres >= m / 2) || (sres < -(m / 2));
    full = full & (m - 1);
    return {v, c, full[15:0]};
  endfunction

  function automatic void chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];
  int          acc_q0[$];
  int          acc_q1[$];
  logic [17:0] last_res [2];
  logic        prev_ov  [2];

  function automatic void sb_push(input int k, input logic [17:0] e, input int acc);
    if (k == 0) begin exp_q0.push_back(e); acc_q0.push_back(acc); end
    else begin exp_q1.push_back(e); acc_q1.push_back(acc); end
  endfunction

  function automatic int sb_size(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [17:0] sb_exp(input int k);
    return (k == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  function automatic int sb_acc(input int k);
    return (k == 0) ? acc_q0[0] : acc_q1[0];
  endfunction

  function automatic void sb_pop(input int k);
    if (k == 0) begin void'(exp_q0.pop_front()); void'(acc_q0.pop_front()); end
    else begin void'(exp_q1.pop_front()); void'(acc_q1.pop_front()); end
  endfunction

  function automatic void sb_flush(input int k);
    if (k == 0) begin exp_q0.delete(); acc_q0.delete(); end
    else begin exp_q1.delete(); acc_q1.delete(); end
  endfunction

  // One compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      obs_t o;
      o = obs(k);
      if (!rst_n_s[k]) begin
        sb_flush(k);
        last_res[k] = '0;
        prev_ov[k]  = 1'b0;
        chk($sformatf("reset_outputs[%0d]", k), o.res, 18'h0);
        chk_int($sformatf("reset_out_valid[%0d]", k), int'(o.ov), 0);
      end else if (o.ov) begin
        if (sb_size(k) == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_result[%0d]: got %h expected no result", k, o.res);
        end else begin
          chk($sformatf("result[%0d]", k), o.res, sb_exp(k));
          chk_int($sformatf("in_ready_in_done[%0d]", k), int'(o.ir), 0);
          if (!prev_ov[k])
            chk_int($sformatf("latency[%0d]", k), cyc - sb_acc(k), nch(k));
          if (out_ready_s[k]) begin
            last_res[k] = sb_exp(k);
            sb_pop(k);
          end
        end
      end else if (o.ir) begin
        chk($sformatf("idle_hold[%0d]", k), o.res, last_res[k]);
      end
      prev_ov[k] = o.ov;
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        case (rmode[k])
          0: out_ready_s[k] = 1'b1;
          1: out_ready_s[k] = ($urandom_range(0, 3) != 0);
          default: ;
        endcase
      end
    end
  end

  // Waits (bounded) for an idle cycle, presents the operands there so the
  // accept lands on the next rising edge, then scrambles the inputs.
  task automatic issue(input int k, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic sb);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!obs(k).ir && n < 200);
    if (!obs(k).ir) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout[%0d]: in_ready low for %0d cycles, required 1", k, n);
      return;
    end
    in_valid_s[k] = 1'b1;
    a_s[k] = av; b_s[k] = bv; cin_s[k] = ci; sub_s[k] = sb;
    sb_push(k, model(wid(k), av, bv, ci, sb), cyc + 1);
    @(posedge clk);
    #1;
    in_valid_s[k] = 1'b0;
    a_s[k] = 16'($urandom); b_s[k] = 16'($urandom);
    cin_s[k] = 1'($urandom_range(0, 1)); sub_s[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!obs(k).ov && n < 100);
    if (!obs(k).ov) begin
      checks++;
      failures++;
      $display("FAIL wait_valid_timeout[%0d]: out_valid low for %0d cycles, required 1", k, n);
    end
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (sb_size(k) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk_int($sformatf("drain_pending[%0d]", k), sb_size(k), 0);
  endtask

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 9))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'h07FF;
      5: return 16'h0800;
      default: return 16'($urandom);
    endcase
  endfunction

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[8];
  obs_t held;

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n_s[k] = 1'b0; in_valid_s[k] = 1'b0; sub_s[k] = 1'b0; cin_s[k] = 1'b0;
      out_ready_s[k] = 1'b1; a_s[k] = '0; b_s[k] = '0; rmode[k] = 0;
      last_res[k] = '0; prev_ov[k] = 1'b0;
    end

    // Hand-computed values pin the model itself.
    chk("model_00ff_plus_1", model(16, 16'h00FF, 16'h0001, 1'b0, 1'b0), {1'b0, 1'b0, 16'h0100});
    chk("model_ffff_plus_1_c", model(16, 16'hFFFF, 16'h0001, 1'b1, 1'b0), {1'b0, 1'b1, 16'h0001});
    chk("model_7fff_plus_1", model(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0), {1'b1, 1'b0, 16'h8000});
    chk("model_0_minus_1", model(16, 16'h0000, 16'h0001, 1'b0, 1'b1), {1'b0, 1'b0, 16'hFFFF});
    chk("model_8000_minus_1", model(16, 16'h8000, 16'h0001, 1'b1, 1'b1), {1'b1, 1'b1, 16'h7FFF});
    chk("model_w12_fff_plus_1", model(12, 16'h0FFF, 16'h0001, 1'b0, 1'b0), {1'b0, 1'b1, 16'h0000});

    repeat (3) @(posedge clk);
    #1;
    rst_n_s[0] = 1'b1;
    rst_n_s[1] = 1'b1;
    @(negedge clk);
    chk_int("in_ready_after_reset[0]", int'(in_ready0), 1);
    chk_int("in_ready_after_reset[1]", int'(in_ready1), 1);

    // Directed vectors: a, b, cin, sub -> sum, cout, ovf.
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      issue(0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_valid(0);
      chk($sformatf("directed_%0d", i), obs(0).res, {vecs[i].v, vecs[i].c, vecs[i].s});
    end
    issue(1, 16'h0FFF, 16'h0001, 1'b0, 1'b0);
    wait_valid(1);
    chk("directed_w12_wrap", obs(1).res, {1'b0, 1'b1, 16'h0000});
    issue(1, 16'h07FF, 16'h0001, 1'b0, 1'b0);
    wait_valid(1);
    chk("directed_w12_ovf", obs(1).res, {1'b1, 1'b0, 16'h0800});
    drain(0);

    // Consumer stalls in DONE; input pulses must be ignored.
    rmode[0] = 3;
    out_ready_s[0] = 1'b0;
    issue(0, 16'h4321, 16'h1111, 1'b1, 1'b0);
    wait_valid(0);
    held = obs(0);
    chk("stall_first_value", held.res, {1'b0, 1'b0, 16'h5433});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid_s[0] = 1'($urandom_range(0, 1));
      a_s[0] = 16'($urandom);
      b_s[0] = 16'($urandom);
      @(negedge clk);
      chk($sformatf("stall_hold_%0d", i), obs(0).res, held.res);
      chk_int($sformatf("stall_flags_%0d", i), {30'd0, obs(0).ov, obs(0).ir}, 2);
    end
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b1;
    out_ready_s[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    @(negedge clk);
    chk_int("no_accept_on_handshake", {30'd0, obs(0).ov, obs(0).ir}, 1);
    rmode[0] = 0;

    // Reset in the middle of CALC with idx=2; the operation is dropped.
    issue(0, 16'h1357, 16'h2468, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk_int("calc_before_reset", int'(st0), int'(CALC));
    rst_n_s[0] = 1'b0;
    #1;
    chk("abort_outputs", {ovf0, cout0, sum0}, 18'h0);
    chk_int("abort_out_valid", int'(out_valid0), 0);
    chk_int("abort_state", int'(st0), int'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst_n_s[0] = 1'b1;
    issue(0, 16'h1357, 16'h2468, 1'b0, 1'b0);
    wait_valid(0);
    chk("after_abort", obs(0).res, {1'b0, 1'b0, 16'h37BF});
    drain(0);

    // Random operations with random gaps and consumer back-pressure.
    rmode[0] = 1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(0, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain(0);
    rmode[1] = 1;
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain(1);
    @(negedge clk);
    chk_int("end_idle[0]", int'(st0), int'(IDLE));
    chk_int("end_idle[1]", int'(st1), int'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
